// File: rtl/calc_arbiter.sv
// calc_arbiter: two-port round-robin arbiter in front of a single shared
// 4-bit signed calculator (add/sub/abs with overflow). The winner's operands
// are latched, the result is registered and held until the owner
// acknowledges it or the ACK_TIMEOUT wait expires.
// Optional feature: define CALC_OVF_CNT_EN to add the saturating 8-bit
// overflow counter and its ovf_count port.
module calc_arbiter #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  input  logic       ack0,
  input  logic       ack1,
  output logic [3:0] res,
  output logic       ovf,
  output logic       timeout,
  output logic       busy
`ifdef CALC_OVF_CNT_EN
  ,
  output logic [7:0] ovf_count
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  // Last wait-counter value before the result is dropped.
  localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       owner, owner_nxt;
  logic       rr, rr_nxt;
  logic [2:0] op_q, op_nxt;
  logic [3:0] a_q, a_nxt;
  logic [3:0] b_q, b_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       gnt0_nxt, gnt1_nxt;
  logic       done0_nxt, done1_nxt;
  logic [3:0] res_nxt;
  logic       ovf_nxt;
  logic       timeout_nxt;
  logic       busy_nxt;
  logic       win;
  logic       ack_own;

  logic [3:0] calc_x, calc_y;
  logic [3:0] calc_res;
  logic       calc_ovf;

  // Shared calculator, fed only from the latched operands; op[2] swaps the
  // operand order, op[1] selects abs of the second operand.
  always_comb begin
    calc_x   = op_q[2] ? b_q : a_q;
    calc_y   = op_q[2] ? a_q : b_q;
    calc_res = 4'd0;
    calc_ovf = 1'b0;
    if (op_q[1]) begin
      calc_res = calc_y[3] ? (4'd0 - calc_y) : calc_y;
      calc_ovf = (calc_y == 4'b1000);
    end else if (op_q[0]) begin
      calc_res = calc_x - calc_y;
      calc_ovf = (calc_x[3] != calc_y[3]) && (calc_res[3] != calc_x[3]);
    end else begin
      calc_res = calc_x + calc_y;
      calc_ovf = (calc_x[3] == calc_y[3]) && (calc_res[3] != calc_x[3]);
    end
  end

  // Next-state and next-output logic for the IDLE/EXEC/DONE sequencer.
  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    rr_nxt      = rr;
    op_nxt      = op_q;
    a_nxt       = a_q;
    b_nxt       = b_q;
    wait_nxt    = wait_cnt;
    gnt0_nxt    = 1'b0;
    gnt1_nxt    = 1'b0;
    done0_nxt   = done0;
    done1_nxt   = done1;
    res_nxt     = res;
    ovf_nxt     = ovf;
    timeout_nxt = 1'b0;
    busy_nxt    = busy;
    win         = (req0 && req1) ? rr : req1;
    ack_own     = owner ? ack1 : ack0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_nxt = win;
          op_nxt    = win ? op1 : op0;
          a_nxt     = win ? a1  : a0;
          b_nxt     = win ? b1  : b0;
          gnt0_nxt  = ~win;
          gnt1_nxt  = win;
          busy_nxt  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        res_nxt   = calc_res;
        ovf_nxt   = calc_ovf;
        done0_nxt = ~owner;
        done1_nxt = owner;
        wait_nxt  = 8'd0;
        state_nxt = DONE;
      end
      DONE: begin
        if (ack_own || (wait_cnt == WAIT_LAST)) begin
          timeout_nxt = ~ack_own;
          done0_nxt   = 1'b0;
          done1_nxt   = 1'b0;
          rr_nxt      = ~owner;
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, latched operands and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      rr       <= 1'b0;
      op_q     <= 3'd0;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      wait_cnt <= 8'd0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      res      <= 4'd0;
      ovf      <= 1'b0;
      timeout  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr       <= rr_nxt;
      op_q     <= op_nxt;
      a_q      <= a_nxt;
      b_q      <= b_nxt;
      wait_cnt <= wait_nxt;
      gnt0     <= gnt0_nxt;
      gnt1     <= gnt1_nxt;
      done0    <= done0_nxt;
      done1    <= done1_nxt;
      res      <= res_nxt;
      ovf      <= ovf_nxt;
      timeout  <= timeout_nxt;
      busy     <= busy_nxt;
    end
  end

`ifdef CALC_OVF_CNT_EN
  // Saturating count of overflowing captures, including later-dropped ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= 8'd0;
    end else if ((state == EXEC) && calc_ovf && (ovf_count != 8'hFF)) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of calc_arbiter (ACK_TIMEOUT = 4).
module tb_calc_arbiter;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [2:0] op0, op1;
  logic [3:0] a0, b0, a1, b1;
  logic       ack0, ack1;
  logic       gnt0, gnt1, done0, done1;
  logic [3:0] res;
  logic       ovf, timeout, busy;
`ifdef CALC_OVF_CNT_EN
  logic [7:0] ovf_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int         m_phase, m_owner, m_rr, m_dwell;
  logic [2:0] m_op;
  logic [3:0] m_a, m_b;
  logic       exp_gnt0, exp_gnt1, exp_done0, exp_done1, exp_ovf, exp_to, exp_busy;
  logic [3:0] exp_res;
  int         exp_cnt;

  int to_seen;
  int gnt_order[$];

  calc_arbiter #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .ack0(ack0), .ack1(ack1),
    .res(res), .ovf(ovf), .timeout(timeout), .busy(busy)
`ifdef CALC_OVF_CNT_EN
    , .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic r1,
                               input logic [2:0] o0, input logic [3:0] x0, input logic [3:0] y0,
                               input logic [2:0] o1, input logic [3:0] x1, input logic [3:0] y1,
                               input logic k0, input logic k1);
    req0 = r0; req1 = r1;
    op0 = o0; a0 = x0; b0 = y0;
    op1 = o1; a1 = x1; b1 = y1;
    ack0 = k0; ack1 = k1;
  endtask

  function automatic int sx(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  // Exact integer arithmetic, then truncate; overflow is "out of 4-bit range".
  task automatic calcRef(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] r, output logic o);
    int x, y, e;
    x = op[2] ? sx(b) : sx(a);
    y = op[2] ? sx(a) : sx(b);
    if (op[1])      e = (y < 0) ? -y : y;
    else if (op[0]) e = x - y;
    else            e = x + y;
    r = e[3:0];
    o = (e > 7) || (e < -8);
  endtask

  task automatic modelReset();
    m_phase = 0; m_owner = 0; m_rr = 0; m_dwell = 0;
    m_op = 3'd0; m_a = 4'd0; m_b = 4'd0;
    exp_gnt0 = 0; exp_gnt1 = 0; exp_done0 = 0; exp_done1 = 0;
    exp_res = 4'd0; exp_ovf = 0; exp_to = 0; exp_busy = 0; exp_cnt = 0;
  endtask

  task automatic modelStep();
    logic ack_own;
    exp_gnt0 = 0; exp_gnt1 = 0; exp_to = 0;
    case (m_phase)
      0: if (req0 || req1) begin
        m_owner = (req0 && req1) ? m_rr : (req1 ? 1 : 0);
        if (m_owner == 0) begin m_op = op0; m_a = a0; m_b = b0; exp_gnt0 = 1; end
        else              begin m_op = op1; m_a = a1; m_b = b1; exp_gnt1 = 1; end
        exp_busy = 1;
        m_phase = 1;
      end
      1: begin
        calcRef(m_op, m_a, m_b, exp_res, exp_ovf);
        if (exp_ovf && exp_cnt < 255) exp_cnt++;
        if (m_owner == 0) exp_done0 = 1; else exp_done1 = 1;
        m_dwell = 0;
        m_phase = 2;
      end
      default: begin
        ack_own = (m_owner == 0) ? ack0 : ack1;
        if (ack_own || (m_dwell + 1 == TO)) begin
          exp_to = !ack_own;
          exp_done0 = 0; exp_done1 = 0;
          exp_busy = 0;
          m_rr = 1 - m_owner;
          m_phase = 0;
        end else begin
          m_dwell++;
        end
      end
    endcase
  endtask

  task automatic checkAll();
    checkOutput("gnt0", 32'(gnt0), 32'(exp_gnt0));
    checkOutput("gnt1", 32'(gnt1), 32'(exp_gnt1));
    checkOutput("done0", 32'(done0), 32'(exp_done0));
    checkOutput("done1", 32'(done1), 32'(exp_done1));
    checkOutput("res", 32'(res), 32'(exp_res));
    checkOutput("ovf", 32'(ovf), 32'(exp_ovf));
    checkOutput("timeout", 32'(timeout), 32'(exp_to));
    checkOutput("busy", 32'(busy), 32'(exp_busy));
`ifdef CALC_OVF_CNT_EN
    checkOutput("ovf_count", 32'(ovf_count), exp_cnt);
`endif
  endtask

  // One clock: model advances on the same edge, outputs checked 1 unit later.
  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1;
    if (timeout === 1'b1) to_seen++;
    if (gnt0 === 1'b1) gnt_order.push_back(0);
    if (gnt1 === 1'b1) gnt_order.push_back(1);
    checkAll();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic flush();
    applyStimulus(0, 0, 3'd0, 4'd0, 4'd0, 3'd0, 4'd0, 4'd0, 1, 1);
    runCycles(4);
  endtask

  // One transaction on a single port with explicit expected result.
  task automatic runReq(input int port, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] er, input logic eo);
    if (port == 0) applyStimulus(1, 0, op, a, b, 3'd0, 4'd0, 4'd0, 0, 0);
    else           applyStimulus(0, 1, 3'd0, 4'd0, 4'd0, op, a, b, 0, 0);
    cycle();
    checkOutput("rq_gnt", 32'(port == 0 ? gnt0 : gnt1), 32'd1);
    applyStimulus(0, 0, 3'd0, 4'd0, 4'd0, 3'd0, 4'd0, 4'd0, 0, 0);
    cycle();
    checkOutput("rq_done", 32'(port == 0 ? done0 : done1), 32'd1);
    checkOutput("rq_res", 32'(res), 32'(er));
    checkOutput("rq_ovf", 32'(ovf), 32'(eo));
    if (port == 0) ack0 = 1; else ack1 = 1;
    cycle();
    checkOutput("rq_idle", 32'(busy), 32'd0);
    ack0 = 0; ack1 = 0;
  endtask

  initial begin
    int saved;
    rst_n = 1'b0;
    to_seen = 0;
    applyStimulus(0, 0, 3'd0, 4'd0, 4'd0, 3'd0, 4'd0, 4'd0, 0, 0);
    modelReset();
    #12;
    checkAll();
    rst_n = 1'b1;

    // Contention from reset with both acks held: grants alternate 0,1,0,1.
    gnt_order.delete();
    applyStimulus(1, 1, 3'd0, 4'd1, 4'd1, 3'd1, 4'd5, 4'd2, 1, 1);
    runCycles(12);
    checkOutput("alt_count", 32'(gnt_order.size() >= 4), 32'd1);
    if (gnt_order.size() >= 4)
      for (int k = 0; k < 4; k++) checkOutput("alt_order", gnt_order[k], k % 2);
    flush();

    // Single request and the overflow / abs cases.
    runReq(0, 3'b000, 4'b0011, 4'b0010, 4'b0101, 1'b0);
    runReq(1, 3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b1);
    runReq(1, 3'b110, 4'b1000, 4'b0000, 4'b1000, 1'b1);
    runReq(1, 3'b010, 4'b0000, 4'b1101, 4'b0011, 1'b0);

    // Timeout: port 0 never acks while port 1 waits; port 1 is granted next.
    flush();
    applyStimulus(1, 0, 3'b001, 4'd2, 4'd5, 3'b000, 4'd1, 4'd1, 0, 0);
    cycle();
    applyStimulus(0, 1, 3'b001, 4'd2, 4'd5, 3'b000, 4'd1, 4'd1, 0, 1'b0);
    saved = to_seen;
    runCycles(5);
    checkOutput("to_pulses", to_seen - saved, 1);
    checkOutput("to_done0", 32'(done0), 32'd0);
    cycle();
    checkOutput("to_next_gnt1", 32'(gnt1), 32'd1);
    req1 = 0;
    flush();

    // Ack on the last allowed DONE cycle wins over the timeout.
    applyStimulus(1, 0, 3'b101, 4'd3, 4'd7, 3'd0, 4'd0, 4'd0, 0, 1);
    cycle();
    req0 = 0;
    saved = to_seen;
    runCycles(4);
    checkOutput("late_done0", 32'(done0), 32'd1);
    ack0 = 1;
    cycle();
    checkOutput("late_no_to", to_seen - saved, 0);
    checkOutput("late_done0_clr", 32'(done0), 32'd0);
    flush();

    // Reset while in DONE clears everything at once; port 0 is favoured after.
    applyStimulus(0, 1, 3'd0, 4'd0, 4'd0, 3'b000, 4'd6, 4'd1, 0, 0);
    runCycles(2);
    checkOutput("pre_rst_done1", 32'(done1), 32'd1);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_done1", 32'(done1), 32'd0);
    checkOutput("rst_res", 32'(res), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkAll();
    #3;
    rst_n = 1'b1;
    applyStimulus(1, 1, 3'b000, 4'd1, 4'd2, 3'b000, 4'd3, 4'd4, 1, 1);
    cycle();
    checkOutput("post_rst_gnt0", 32'(gnt0), 32'd1);
    flush();

`ifdef CALC_OVF_CNT_EN
    // 300 overflowing operations saturate the counter.
    applyStimulus(1, 0, 3'b000, 4'b0111, 4'b0001, 3'd0, 4'd0, 4'd0, 1, 0);
    runCycles(900);
    checkOutput("ovf_cnt_sat", 32'(ovf_count), 32'd255);
    flush();
`endif

    // Randomized traffic, including ignored acks on the non-owning port.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                    3'($urandom), 4'($urandom), 4'($urandom),
                    3'($urandom), 4'($urandom), 4'($urandom),
                    $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
